// File: rtl/instruction_loader_if.sv
// Byte-stream loader bus: host-side request/byte stream plus instruction
// memory write port and CPU status. Handshake: a byte moves only in a cycle
// where rx_valid and rx_ready are both high at the rising clock edge;
// rx_ready never depends on rx_valid, and the host holds rx_data stable while
// rx_valid is high and rx_ready is low.
`timescale 1ns/1ps
interface instruction_loader_if;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] word_count;

  // Host / byte source side
  modport master (
    output start, rx_data, rx_valid,
    input  rx_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error, word_count
  );

  // Loader side
  modport slave (
    input  start, rx_data, rx_valid,
    output rx_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error, word_count
  );
endinterface

// File: rtl/instruction_loader.sv
// Instruction loader: receives a 16-bit big-endian word count followed by
// that many 32-bit words (MSB first) and writes them to instruction memory
// at consecutive word addresses, holding the CPU frozen until done.
`timescale 1ns/1ps
module instruction_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  instruction_loader_if.slave  bus,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  localparam logic [31:0] MAX_WORDS_U = 32'(MAX_WORDS);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] word_count_q;
  logic [15:0] index_q;
  logic [1:0]  byte_cnt_q;
  logic [23:0] acc_q;
  logic        wr_en_q;
  logic [31:0] wr_addr_q;
  logic [31:0] wr_data_q;

  logic        rx_ready;
  logic        done;
  logic        error;
  logic        cpu_hold;
  logic        xfer;
  logic        start_ok;
  logic [15:0] hdr_count;
  logic        hdr_bad;
  logic        word_end;
  logic        last_word;

  // Start is honoured only when no load is in progress.
  assign start_ok  = bus.start && (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign xfer      = bus.rx_valid && rx_ready;
  // Count formed by the low header byte currently on the bus.
  assign hdr_count = {word_count_q[15:8], bus.rx_data};
  assign hdr_bad   = (hdr_count == 16'd0) || ({16'h0, hdr_count} > MAX_WORDS_U);
  assign word_end  = xfer && (state == S_DATA) && (byte_cnt_q == 2'd3);
  assign last_word = (index_q == word_count_q - 16'd1);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start_ok) state_nxt = S_LEN_HI;
      S_LEN_HI:              if (xfer) state_nxt = S_LEN_LO;
      S_LEN_LO:              if (xfer) state_nxt = hdr_bad ? S_ERR : S_DATA;
      S_DATA:                if (word_end && last_word) state_nxt = S_DONE;
      default:               state_nxt = S_IDLE;
    endcase
  end

  // Status outputs; done waits out the final write pulse in the first DONE cycle
  always_comb begin
    rx_ready = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    cpu_hold = 1'b1;
    case (state)
      S_LEN_HI, S_LEN_LO, S_DATA: rx_ready = 1'b1;
      S_DONE: begin
        done     = ~wr_en_q;
        cpu_hold = wr_en_q;
      end
      S_ERR:   error = 1'b1;
      default: ;
    endcase
  end

  // Header capture, byte assembly and the registered memory write port
  always_ff @(posedge clk) begin
    if (reset) begin
      word_count_q <= 16'd0;
      index_q      <= 16'd0;
      byte_cnt_q   <= 2'd0;
      acc_q        <= 24'd0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= BASE_ADDR;
      wr_data_q    <= 32'd0;
    end else begin
      wr_en_q <= word_end;
      if (start_ok) begin
        index_q    <= 16'd0;
        byte_cnt_q <= 2'd0;
      end
      if (xfer && state == S_LEN_HI) word_count_q[15:8] <= bus.rx_data;
      if (xfer && state == S_LEN_LO) word_count_q[7:0]  <= bus.rx_data;
      if (xfer && state == S_DATA) begin
        acc_q      <= {acc_q[15:0], bus.rx_data};
        byte_cnt_q <= byte_cnt_q + 2'd1;
        if (byte_cnt_q == 2'd3) begin
          wr_data_q <= {acc_q, bus.rx_data};
          wr_addr_q <= BASE_ADDR + {14'd0, index_q, 2'b00};
          index_q   <= index_q + 16'd1;
        end
      end
    end
  end

  assign bus.rx_ready   = rx_ready;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.cpu_hold   = cpu_hold;
  assign bus.done       = done;
  assign bus.error      = error;
  assign bus.word_count = word_count_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: byte-stream driver, stream-level reference
// model feeding an expected-write queue, and a negedge write monitor.
`timescale 1ns/1ps
module tb_instruction_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  state_dbg;
  instruction_loader_if bus();

  instruction_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_q[$];      // {wr_addr, wr_data} expected in order
  logic [7:0]  stream[$];     // byte stream of the next load

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // scoreboard monitor: every write pulse must match the head of exp_q
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%h data=%h expected no write",
                 bus.wr_addr, bus.wr_data);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({bus.wr_addr, bus.wr_data} !== e) begin
          errors++;
          $display("FAIL write: got addr=%h data=%h expected addr=%h data=%h",
                   bus.wr_addr, bus.wr_data, e[63:32], e[31:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Idle for 'gap' cycles, then offer one byte until it is taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    bus.rx_valid = 1'b0;
    repeat (gap) tick();
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    n = 0;
    while (bus.rx_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      errors++;
      checks++;
      $display("FAIL rx_ready_timeout: got rx_ready=%b expected 1", bus.rx_ready);
    end
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"},    32'(state_dbg),      32'd0);
    chk({tag, "_rx_ready"}, 32'(bus.rx_ready),   32'd0);
    chk({tag, "_wr_en"},    32'(bus.wr_en),      32'd0);
    chk({tag, "_wr_addr"},  bus.wr_addr,         BASE);
    chk({tag, "_wr_data"},  bus.wr_data,         32'd0);
    chk({tag, "_cpu_hold"}, 32'(bus.cpu_hold),   32'd1);
    chk({tag, "_done"},     32'(bus.done),       32'd0);
    chk({tag, "_error"},    32'(bus.error),      32'd0);
    chk({tag, "_wcount"},   32'(bus.word_count), 32'd0);
  endtask

  // Run one load of 'stream'. gap<0 means random gaps of 0..4 cycles.
  // start_mid_at >= 0 pulses start just before that byte index.
  task automatic do_load(input string tag, input int gap, input int start_mid_at);
    logic [15:0] hdr;
    bit          ok;
    int          g;
    hdr = {stream[0], stream[1]};
    ok  = (hdr != 16'd0) && (int'(hdr) <= MAXW);
    if (ok) begin
      for (int i = 0; i < int'(hdr); i++) begin
        exp_q.push_back({BASE + 32'(4 * i),
                         stream[2 + 4*i], stream[3 + 4*i], stream[4 + 4*i], stream[5 + 4*i]});
      end
    end
    pulse_start();
    chk({tag, "_hold_at_start"},  32'(bus.cpu_hold), 32'd1);
    chk({tag, "_done_at_start"},  32'(bus.done),     32'd0);
    chk({tag, "_error_at_start"}, 32'(bus.error),    32'd0);
    for (int k = 0; k < stream.size(); k++) begin
      if (k == start_mid_at) pulse_start();
      g = (gap < 0) ? int'($urandom_range(0, 4)) : gap;
      send_byte(stream[k], g);
    end
    if (ok) begin
      chk({tag, "_final_wr_en"}, 32'(bus.wr_en), 32'd1);
      chk({tag, "_done_early"},  32'(bus.done),  32'd0);
      tick();
      chk({tag, "_done"},     32'(bus.done),     32'd1);
      chk({tag, "_cpu_hold"}, 32'(bus.cpu_hold), 32'd0);
      chk({tag, "_error"},    32'(bus.error),    32'd0);
    end else begin
      tick();
      tick();
      chk({tag, "_error"},    32'(bus.error),    32'd1);
      chk({tag, "_cpu_hold"}, 32'(bus.cpu_hold), 32'd1);
      chk({tag, "_done"},     32'(bus.done),     32'd0);
    end
    chk({tag, "_rx_ready"},   32'(bus.rx_ready),   32'd0);
    chk({tag, "_word_count"}, 32'(bus.word_count), 32'(hdr));
    chk({tag, "_pending"},    32'(exp_q.size()),   32'd0);
  endtask

  task automatic random_stream(input int words);
    stream.delete();
    stream.push_back(8'(words >> 8));
    stream.push_back(8'(words));
    for (int i = 0; i < 4 * words; i++) stream.push_back(8'($urandom_range(0, 255)));
  endtask

  // stimulus and report
  initial begin
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    check_reset_values("reset");

    stream = '{8'h00, 8'h02, 8'h08, 8'h10, 8'h00, 8'h03, 8'h3C, 8'h0B, 8'h40, 8'h00};
    do_load("normal", 0, -1);
    do_load("throttled", 3, -1);

    stream = '{8'h00, 8'h00};
    do_load("hdr_zero", 0, -1);
    stream = '{8'h01, 8'h01};
    do_load("hdr_257", 0, -1);
    stream = '{8'($urandom_range(2, 255)), 8'($urandom_range(0, 255))};
    do_load("hdr_big", 1, -1);

    // reset in the middle of a word: nothing written, outputs back to reset
    stream = '{8'h00, 8'h01, 8'hAA, 8'hBB};
    pulse_start();
    foreach (stream[k]) send_byte(stream[k], 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_values("mid_reset");
    tick();
    stream = '{8'h00, 8'h02, 8'h08, 8'h10, 8'h00, 8'h03, 8'h3C, 8'h0B, 8'h40, 8'h00};
    do_load("after_reset", 0, -1);

    stream = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    do_load("reload", 0, 3);

    for (int r = 0; r < 6; r++) begin
      random_stream(int'($urandom_range(1, 6)));
      do_load($sformatf("rand%0d", r), -1, (r == 2) ? 4 : -1);
    end

    random_stream(MAXW);
    do_load("max_words", 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
